// File: rtl/param_register_file_pkg.sv
// Shared definitions for the parametrised register file.
// Contents:
//   DefaultDataWidth / DefaultAddrWidth - default geometry (8-bit x 8 registers)
//   reset_value()                       - power-on value of register idx: idx truncated to width
package param_register_file_pkg;

   localparam int unsigned DefaultDataWidth = 8;
   localparam int unsigned DefaultAddrWidth = 3;

   // Register i resets to i, truncated to the register width. The result is 32 bits wide and
   // callers cast it down to their own data width.
   function automatic logic [31:0] reset_value(input int unsigned idx, input int unsigned width);
      logic [31:0] mask;
      if (width >= 32) begin
         mask = '1;
      end else begin
         mask = (32'd1 << width) - 32'd1;
      end
      return idx & mask;
   endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Decode/writeback bus of the register file.
// Signals:
//   Read_reg_num_1/2 - read port indices (from decode)
//   Read_data_1/2    - read port data (combinational, to decode)
//   Read_busy_1/2    - addressed register has a pending write (to decode)
//   Write_reg_num, Write_data, RegWrite - writeback port
//   Issue_valid, Issue_reg_num          - mark a destination register busy at issue
// Modports: master = pipeline side, slave = register file.
interface param_register_file_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);

   logic [ADDR_WIDTH-1:0] Read_reg_num_1;
   logic [ADDR_WIDTH-1:0] Read_reg_num_2;
   logic [DATA_WIDTH-1:0] Read_data_1;
   logic [DATA_WIDTH-1:0] Read_data_2;
   logic                  Read_busy_1;
   logic                  Read_busy_2;
   logic [ADDR_WIDTH-1:0] Write_reg_num;
   logic [DATA_WIDTH-1:0] Write_data;
   logic                  RegWrite;
   logic                  Issue_valid;
   logic [ADDR_WIDTH-1:0] Issue_reg_num;

   modport master (
      output Read_reg_num_1, Read_reg_num_2, Write_reg_num, Write_data, RegWrite,
             Issue_valid, Issue_reg_num,
      input  Read_data_1, Read_data_2, Read_busy_1, Read_busy_2
   );

   modport slave (
      input  Read_reg_num_1, Read_reg_num_2, Write_reg_num, Write_data, RegWrite,
             Issue_valid, Issue_reg_num,
      output Read_data_1, Read_data_2, Read_busy_1, Read_busy_2
   );

endinterface

// File: rtl/param_register_file_scoreboard.sv
// Per-register busy scoreboard used for RAW hazard detection.
// Ports:
//   clk_i                 - clock, state updates on rising edge
//   rst_i                 - synchronous active-high reset, clears all busy bits
//   set_i, set_idx_i      - mark a register busy (new producer issued)
//   clr_i, clr_idx_i      - clear a register's busy bit (writeback)
//   rd_idx_1_i/rd_idx_2_i - read port indices
//   busy_1_o/busy_2_o     - registered busy bits of the addressed registers
module param_register_file_scoreboard #(
   parameter int unsigned AddrWidth = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 set_i,
   input  logic [AddrWidth-1:0] set_idx_i,
   input  logic                 clr_i,
   input  logic [AddrWidth-1:0] clr_idx_i,
   input  logic [AddrWidth-1:0] rd_idx_1_i,
   input  logic [AddrWidth-1:0] rd_idx_2_i,
   output logic                 busy_1_o,
   output logic                 busy_2_o
);

   localparam int unsigned NumRegs = 2 ** AddrWidth;

   logic [NumRegs-1:0] busy_q;
   logic [NumRegs-1:0] busy_d;

   // Set is applied after clear so a new producer issued in the same cycle as the old
   // producer's writeback keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (clr_i) begin
         busy_d[clr_idx_i] = 1'b0;
      end
      if (set_i) begin
         busy_d[set_idx_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_1_o = busy_q[rd_idx_1_i];
   assign busy_2_o = busy_q[rd_idx_2_i];

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: DATA_WIDTH x 2**ADDR_WIDTH registers, two combinational read
// ports, one synchronous write port, optional write-to-read bypass, optional hardwired zero
// register, and a busy scoreboard for in-flight writebacks.
// Ports:
//   Clk   - clock, all state updates on rising edge
//   Reset - synchronous active-high reset; registers load their index, busy bits clear
//   rf_io - decode/writeback bus (slave side), see param_register_file_if
module param_register_file
   import param_register_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
   parameter bit          ZERO_REG   = 1'b0,
   parameter bit          BYPASS     = 1'b1
) (
   input logic                  Clk,
   input logic                  Reset,
   param_register_file_if.slave rf_io
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic write_en;
   logic issue_en;
   logic hit_1, hit_2;
   logic claim_1, claim_2;
   logic busy_raw_1, busy_raw_2;

   // With a zero register, index 0 takes neither writes nor issues; masking the enables here
   // also keeps index 0 out of bypass matching and the scoreboard.
   assign write_en = rf_io.RegWrite &&
                     !(ZERO_REG && (rf_io.Write_reg_num == '0));
   assign issue_en = rf_io.Issue_valid &&
                     !(ZERO_REG && (rf_io.Issue_reg_num == '0));

   always_comb begin
      regs_d = regs_q;
      if (write_en) begin
         regs_d[rf_io.Write_reg_num] = rf_io.Write_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= DATA_WIDTH'(reset_value(i, DATA_WIDTH));
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   param_register_file_scoreboard #(
      .AddrWidth (ADDR_WIDTH)
   ) u_scoreboard (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .set_i      (issue_en),
      .set_idx_i  (rf_io.Issue_reg_num),
      .clr_i      (write_en),
      .clr_idx_i  (rf_io.Write_reg_num),
      .rd_idx_1_i (rf_io.Read_reg_num_1),
      .rd_idx_2_i (rf_io.Read_reg_num_2),
      .busy_1_o   (busy_raw_1),
      .busy_2_o   (busy_raw_2)
   );

   // A bypass hit means this cycle's writeback lands on the port's register.
   assign hit_1 = BYPASS && !Reset && write_en &&
                  (rf_io.Write_reg_num == rf_io.Read_reg_num_1);
   assign hit_2 = BYPASS && !Reset && write_en &&
                  (rf_io.Write_reg_num == rf_io.Read_reg_num_2);
   assign claim_1 = issue_en && (rf_io.Issue_reg_num == rf_io.Read_reg_num_1);
   assign claim_2 = issue_en && (rf_io.Issue_reg_num == rf_io.Read_reg_num_2);

   function automatic logic [DATA_WIDTH-1:0] pick_data(
      input logic                  rst,
      input logic [ADDR_WIDTH-1:0] idx,
      input logic                  hit,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [DATA_WIDTH-1:0] stored
   );
      logic [DATA_WIDTH-1:0] result;
      if (rst) begin
         // Registers are being reset this edge; show the value they are about to take.
         result = DATA_WIDTH'(reset_value(32'(idx), DATA_WIDTH));
      end else if (ZERO_REG && (idx == '0)) begin
         result = '0;
      end else if (hit) begin
         result = wdata;
      end else begin
         result = stored;
      end
      return result;
   endfunction

   // A bypassed writeback satisfies the hazard in the same cycle, unless a new producer for
   // the same register is issued alongside it.
   function automatic logic pick_busy(
      input logic rst,
      input logic hit,
      input logic claim,
      input logic raw
   );
      logic result;
      if (rst) begin
         result = 1'b0;
      end else if (hit && !claim) begin
         result = 1'b0;
      end else begin
         result = raw;
      end
      return result;
   endfunction

   always_comb begin
      rf_io.Read_data_1 = pick_data(Reset, rf_io.Read_reg_num_1, hit_1, rf_io.Write_data,
                                    regs_q[rf_io.Read_reg_num_1]);
      rf_io.Read_data_2 = pick_data(Reset, rf_io.Read_reg_num_2, hit_2, rf_io.Write_data,
                                    regs_q[rf_io.Read_reg_num_2]);
      rf_io.Read_busy_1 = pick_busy(Reset, hit_1, claim_1, busy_raw_1);
      rf_io.Read_busy_2 = pick_busy(Reset, hit_2, claim_2, busy_raw_2);
   end

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file. Three builds run side by side:
//   0: 8-bit x 8,  ZERO_REG=0, BYPASS=1
//   1: 8-bit x 8,  ZERO_REG=1, BYPASS=0
//   2: 16-bit x 32, ZERO_REG=1, BYPASS=1
// A directed sequence with literal expectations is followed by random traffic; a reference
// model of the register contents and busy bits is checked against every build each cycle.
module tb_param_register_file;

   localparam int DW [3] = '{8, 8, 16};
   localparam int AW [3] = '{3, 3, 5};
   localparam bit ZR [3] = '{1'b0, 1'b1, 1'b1};
   localparam bit BP [3] = '{1'b1, 1'b0, 1'b1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [3];
   logic [4:0]  r1   [3];
   logic [4:0]  r2   [3];
   logic [4:0]  widx [3];
   logic [15:0] wd   [3];
   logic        we   [3];
   logic        iss  [3];
   logic [4:0]  iidx [3];

   wire [15:0] d1 [3];
   wire [15:0] d2 [3];
   wire        b1 [3];
   wire        b2 [3];

   int checks   = 0;
   int failures = 0;

   param_register_file_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(3)) if0 ();
   param_register_file_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(3)) if1 ();
   param_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) if2 ();

   param_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b0), .BYPASS(1'b1))
      dut0 (.Clk(clk), .Reset(rst[0]), .rf_io(if0));
   param_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1), .BYPASS(1'b0))
      dut1 (.Clk(clk), .Reset(rst[1]), .rf_io(if1));
   param_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
      dut2 (.Clk(clk), .Reset(rst[2]), .rf_io(if2));

   assign if0.Read_reg_num_1 = r1[0][2:0];
   assign if0.Read_reg_num_2 = r2[0][2:0];
   assign if0.Write_reg_num  = widx[0][2:0];
   assign if0.Write_data     = wd[0][7:0];
   assign if0.RegWrite       = we[0];
   assign if0.Issue_valid    = iss[0];
   assign if0.Issue_reg_num  = iidx[0][2:0];
   assign d1[0] = {8'h00, if0.Read_data_1};
   assign d2[0] = {8'h00, if0.Read_data_2};
   assign b1[0] = if0.Read_busy_1;
   assign b2[0] = if0.Read_busy_2;

   assign if1.Read_reg_num_1 = r1[1][2:0];
   assign if1.Read_reg_num_2 = r2[1][2:0];
   assign if1.Write_reg_num  = widx[1][2:0];
   assign if1.Write_data     = wd[1][7:0];
   assign if1.RegWrite       = we[1];
   assign if1.Issue_valid    = iss[1];
   assign if1.Issue_reg_num  = iidx[1][2:0];
   assign d1[1] = {8'h00, if1.Read_data_1};
   assign d2[1] = {8'h00, if1.Read_data_2};
   assign b1[1] = if1.Read_busy_1;
   assign b2[1] = if1.Read_busy_2;

   assign if2.Read_reg_num_1 = r1[2];
   assign if2.Read_reg_num_2 = r2[2];
   assign if2.Write_reg_num  = widx[2];
   assign if2.Write_data     = wd[2];
   assign if2.RegWrite       = we[2];
   assign if2.Issue_valid    = iss[2];
   assign if2.Issue_reg_num  = iidx[2];
   assign d1[2] = if2.Read_data_1;
   assign d2[2] = if2.Read_data_2;
   assign b1[2] = if2.Read_busy_1;
   assign b2[2] = if2.Read_busy_2;

   // Reference model: architectural register contents and pending-write flags.
   logic [15:0] m_reg  [3][32];
   logic        m_busy [3][32];
   bit          m_valid [3] = '{1'b0, 1'b0, 1'b0};

   function automatic logic [15:0] dmask(int k);
      return (DW[k] == 16) ? 16'hFFFF : 16'h00FF;
   endfunction

   function automatic bit fwd(int k, logic [4:0] idx);
      return BP[k] && we[k] && (widx[k] == idx) && !(ZR[k] && idx == 5'd0);
   endfunction

   function automatic logic [15:0] exp_data(int k, logic [4:0] idx);
      if (rst[k])                return 16'(idx) & dmask(k);
      if (ZR[k] && idx == 5'd0)  return 16'h0000;
      if (fwd(k, idx))           return wd[k] & dmask(k);
      return m_reg[k][idx];
   endfunction

   function automatic logic exp_busy(int k, logic [4:0] idx);
      if (rst[k])                return 1'b0;
      if (ZR[k] && idx == 5'd0)  return 1'b0;
      if (fwd(k, idx) && !(iss[k] && iidx[k] == idx)) return 1'b0;
      return m_busy[k][idx];
   endfunction

   task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   // Compare every build against the model, then advance the model by the upcoming edge.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (m_valid[k] || rst[k]) begin
            chk($sformatf("model_d1[%0d]", k), d1[k], exp_data(k, r1[k]));
            chk($sformatf("model_d2[%0d]", k), d2[k], exp_data(k, r2[k]));
            chk($sformatf("model_b1[%0d]", k), 16'(b1[k]), 16'(exp_busy(k, r1[k])));
            chk($sformatf("model_b2[%0d]", k), 16'(b2[k]), 16'(exp_busy(k, r2[k])));
         end
         if (rst[k]) begin
            for (int i = 0; i < 32; i++) begin
               m_reg[k][i]  = 16'(i) & dmask(k);
               m_busy[k][i] = 1'b0;
            end
            m_valid[k] = 1'b1;
         end else begin
            if (we[k] && !(ZR[k] && widx[k] == 5'd0)) m_reg[k][widx[k]] = wd[k] & dmask(k);
            if (we[k]) m_busy[k][widx[k]] = 1'b0;
            if (iss[k] && !(ZR[k] && iidx[k] == 5'd0)) m_busy[k][iidx[k]] = 1'b1;
         end
      end
   end

   // Apply one cycle of stimulus to all builds; returns with outputs settled mid-cycle.
   task automatic step(bit r, bit w, int wi, int wdv, bit is, int ii, int a1, int a2);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         rst[k]  = r;
         we[k]   = w;
         widx[k] = 5'(wi);
         wd[k]   = 16'(wdv);
         iss[k]  = is;
         iidx[k] = 5'(ii);
         r1[k]   = 5'(a1);
         r2[k]   = 5'(a2);
      end
      #2;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; we[k] = 1'b0; iss[k] = 1'b0; widx[k] = '0; iidx[k] = '0;
         wd[k] = '0; r1[k] = '0; r2[k] = '0;
      end

      // Reset with reads of 3 and 7.
      step(1, 0, 0, 0, 0, 0, 3, 7);
      chk("rst_d1", d1[0], 16'h0003);
      chk("rst_d2", d2[0], 16'h0007);
      chk("rst_b1", 16'(b1[0]), 16'h0000);
      chk("rst_b2", 16'(b2[0]), 16'h0000);
      step(0, 0, 0, 0, 0, 0, 3, 7);
      r2[2] = 5'd31;
      #1;
      chk("post_rst_d1", d1[1], 16'h0003);
      chk("wide_reg31", d2[2], 16'h001F);

      // Write reg5 with same-cycle read.
      step(0, 1, 5, 'hA5, 0, 0, 5, 5);
      chk("bypass_d1", d1[0], 16'h00A5);
      chk("bypass_d2", d2[0], 16'h00A5);
      chk("nobypass_d1", d1[1], 16'h0005);
      step(0, 0, 0, 0, 0, 0, 5, 5);
      chk("wr_next_bp", d1[0], 16'h00A5);
      chk("wr_next_nobp", d1[1], 16'h00A5);

      // Write and issue to register 0.
      step(0, 1, 0, 'hFF, 1, 0, 0, 0);
      chk("r0_plain_d", d1[0], 16'h00FF);
      chk("r0_zero_d", d1[1], 16'h0000);
      chk("r0_zero_b", 16'(b1[1]), 16'h0000);
      chk("r0_zero_wide_d", d1[2], 16'h0000);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_plain_busy", 16'(b1[0]), 16'h0001);
      chk("r0_zero_after_d", d1[1], 16'h0000);
      chk("r0_zero_after_b", 16'(b1[1]), 16'h0000);

      // Issue reg2, then write it back.
      step(0, 0, 0, 0, 1, 2, 2, 2);
      chk("iss2_same_b", 16'(b1[0]), 16'h0000);
      step(0, 1, 2, 'h11, 0, 0, 2, 2);
      chk("wb2_bp_d", d1[0], 16'h0011);
      chk("wb2_bp_b", 16'(b1[0]), 16'h0000);
      chk("wb2_nobp_d", d1[1], 16'h0002);
      chk("wb2_nobp_b", 16'(b1[1]), 16'h0001);
      step(0, 0, 0, 0, 0, 0, 2, 2);
      chk("wb2_next_b", 16'(b1[1]), 16'h0000);
      chk("wb2_next_d", d1[1], 16'h0011);

      // Issue and writeback to reg4 together: set wins.
      step(0, 1, 4, 'h22, 1, 4, 4, 4);
      chk("both4_d", d1[0], 16'h0022);
      step(0, 0, 0, 0, 0, 0, 4, 4);
      chk("both4_next_d", d1[0], 16'h0022);
      chk("both4_next_b", 16'(b1[0]), 16'h0001);
      chk("both4_next_b_nobp", 16'(b1[1]), 16'h0001);

      // Reset beats write and issue.
      step(1, 1, 6, 'h99, 1, 6, 6, 4);
      chk("rstwr_d1", d1[0], 16'h0006);
      chk("rstwr_d2", d2[0], 16'h0004);
      step(0, 0, 0, 0, 0, 0, 6, 4);
      chk("rstwr_next_d", d1[0], 16'h0006);
      chk("rstwr_next_b", 16'(b1[0]), 16'h0000);
      chk("rstwr_next_b2", 16'(b2[0]), 16'h0000);

      // Random traffic, indices biased towards collisions.
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            int unsigned top;
            top     = (32'd1 << AW[k]) - 1;
            rst[k]  = ($urandom_range(0, 63) == 0);
            we[k]   = $urandom_range(0, 1) == 1;
            iss[k]  = $urandom_range(0, 1) == 1;
            wd[k]   = 16'($urandom) & dmask(k);
            widx[k] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, top));
            iidx[k] = ($urandom_range(0, 2) == 0) ? widx[k] : 5'($urandom_range(0, top));
            r1[k]   = ($urandom_range(0, 1) == 0) ? widx[k] : 5'($urandom_range(0, top));
            r2[k]   = ($urandom_range(0, 2) == 0) ? r1[k]
                    : ($urandom_range(0, 1) == 0) ? iidx[k] : 5'($urandom_range(0, top));
         end
      end

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
